// File: rtl/cla_pipe_if.sv
// Operand/result bundle for cla_pipe: valid/ready on the operand side and on the result side.
interface cla_pipe_if #(
  parameter int W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe.sv
// Pipelined CLA add/sub: one W/STAGES slice per stage, latency STAGES, full throughput.
// Backpressure: a stage loads when empty or when its successor loads; no skid buffer.
module cla_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  cla_pipe_if.slave bus
);
  localparam int SW = W / STAGES;
  localparam int NG = SW / 4;

  // Returns {group carry out, carry into bit 3, 4-bit sum}.
  function automatic logic [5:0] cla4(input logic [3:0] a4, input logic [3:0] b4, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       pp;
    g    = a4 & b4;
    p    = a4 | b4;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp   = &p;
    return {gg | (pp & ci), c[3], a4 ^ b4 ^ c};
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [W-1:0]      r_a   [STAGES];
  logic [W-1:0]      r_b   [STAGES];
  logic [W-1:0]      r_sum [STAGES];
  logic              r_ovf;

  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_v_src;
  logic [STAGES-1:0] w_c_src;
  logic [STAGES-1:0] w_c_nxt;
  logic [W-1:0]      w_a_src [STAGES];
  logic [W-1:0]      w_b_src [STAGES];
  logic [W-1:0]      w_s_src [STAGES];
  logic [W-1:0]      w_s_nxt [STAGES];
  logic              w_msb_c;

  // Load chain flattened as an OR over downstream empties to keep it acyclic.
  always_comb begin : p_load
    logic acc;
    w_load = '0;
    acc    = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc       = acc | ~r_vld[k];
      w_load[k] = acc;
    end
  end

  always_comb begin : p_slice
    logic [5:0] r4;
    logic       c;
    int         idx;
    w_msb_c = 1'b0;
    w_v_src = '0;
    w_c_src = '0;
    w_c_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_a_src[k] = '0;
      w_b_src[k] = '0;
      w_s_src[k] = '0;
      w_s_nxt[k] = '0;
    end

    w_v_src[0] = bus.in_valid;
    w_a_src[0] = bus.a;
    w_b_src[0] = bus.sub ? ~bus.b : bus.b;
    w_c_src[0] = bus.sub | bus.cin;
    for (int k = 1; k < STAGES; k++) begin
      w_v_src[k] = r_vld[k-1];
      w_a_src[k] = r_a[k-1];
      w_b_src[k] = r_b[k-1];
      w_c_src[k] = r_c[k-1];
      w_s_src[k] = r_sum[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      c          = w_c_src[k];
      w_s_nxt[k] = w_s_src[k];
      for (int g = 0; g < NG; g++) begin
        idx = k * SW + g * 4;
        r4  = cla4(w_a_src[k][idx +: 4], w_b_src[k][idx +: 4], c);
        w_s_nxt[k][idx +: 4] = r4[3:0];
        if (k == STAGES - 1) begin
          w_msb_c = r4[4];
        end
        c = r4[5];
      end
      w_c_nxt[k] = c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= w_v_src[k];
        end
        // Bubbles advance the valid bit only; data stays put.
        if (w_load[k] && w_v_src[k]) begin
          r_a[k]   <= w_a_src[k];
          r_b[k]   <= w_b_src[k];
          r_sum[k] <= w_s_nxt[k];
          r_c[k]   <= w_c_nxt[k];
        end
      end
      if (w_load[STAGES-1] && w_v_src[STAGES-1]) begin
        r_ovf <= w_msb_c ^ w_c_nxt[STAGES-1];
      end
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.cout      = r_c[STAGES-1];
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cla_pipe.sv
// Scoreboard bench for cla_pipe: W16/S2 main instance, plus S1 and W32/S4 latency variants.
module tb_cla_pipe;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  typedef logic [17:0] res16_t;
  res16_t q16[$];
  res16_t mon_exp;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt [7] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0}
  };

  cla_pipe_if #(.W(16)) if16 ();
  cla_pipe_if #(.W(32)) if32 ();
  cla_pipe_if #(.W(16)) if1 ();

  cla_pipe #(.W(16), .STAGES(2)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  cla_pipe #(.W(32), .STAGES(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  cla_pipe #(.W(16), .STAGES(1)) u1  (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic res16_t m16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    logic [15:0] bb;
    logic [16:0] t;
    logic        ov;
    bb = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {16'd0, (sb | ci)};
    ov = (a[15] == bb[15]) && (t[15] != a[15]);
    return {t[15:0], t[16], ov};
  endfunction

  // Every accepted result of the main instance is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && if16.out_valid && if16.out_ready) begin
      n_chk++;
      if (q16.size() == 0) begin
        $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no output",
                 if16.sum, if16.cout, if16.ovf);
      end else begin
        mon_exp = q16.pop_front();
        if ({if16.sum, if16.cout, if16.ovf} !== mon_exp)
          $display("FAIL scoreboard: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   if16.sum, if16.cout, if16.ovf, mon_exp[17:2], mon_exp[1], mon_exp[0]);
        else
          n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0; if16.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0; if32.sub = 1'b0; if32.out_ready = 1'b1;
    if1.in_valid  = 1'b0; if1.a  = '0; if1.b  = '0; if1.cin  = 1'b0; if1.sub  = 1'b0; if1.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_chk++;
    if ({if16.out_valid, if16.sum, if16.cout, if16.ovf} !== 19'd0)
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, required all zero",
               if16.out_valid, if16.sum, if16.cout, if16.ovf);
    else n_pass++;
    n_chk++;
    if (if16.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", if16.in_ready);
    else n_pass++;
    n_chk++;
    if ({if32.out_valid, if1.out_valid, if32.sum, if1.sum} !== 50'd0)
      $display("FAIL reset_variants: got v32=%b v1=%b s32=%h s1=%h, required zero",
               if32.out_valid, if1.out_valid, if32.sum, if1.sum);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < 7; i++) begin
      if16.a = vt[i].a; if16.b = vt[i].b; if16.cin = vt[i].cin; if16.sub = vt[i].sub;
      if16.in_valid = 1'b1;
      #1;
      n_chk++;
      if (if16.in_ready !== 1'b1) $display("FAIL basic_in_ready[%0d]: got %b, required 1", i, if16.in_ready);
      else n_pass++;
      q16.push_back(m16(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub));
      @(posedge clk); #1;
      if16.in_valid = 1'b0;
      lat = 1;
      while (!if16.out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      n_chk++;
      if (lat !== 2) $display("FAIL basic_latency[%0d]: got %0d, required 2", i, lat);
      else n_pass++;
      n_chk++;
      if ({if16.sum, if16.cout, if16.ovf} !== {vt[i].s, vt[i].co, vt[i].ov})
        $display("FAIL basic_result[%0d]: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 i, if16.sum, if16.cout, if16.ovf, vt[i].s, vt[i].co, vt[i].ov);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if16.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 4) begin
        if16.in_valid = 1'b1;
        if16.a = 16'(sent + 1); if16.b = 16'(sent + 1); if16.cin = 1'b0; if16.sub = 1'b0;
      end else begin
        if16.in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        n_chk++;
        if (if16.in_ready !== 1'b0) $display("FAIL bp_in_ready[c%0d]: got %b, required 0", cyc, if16.in_ready);
        else n_pass++;
        n_chk++;
        if (if16.out_valid !== 1'b1) $display("FAIL bp_out_valid[c%0d]: got %b, required 1", cyc, if16.out_valid);
        else n_pass++;
        n_chk++;
        if (if16.sum !== 16'h0002) $display("FAIL bp_hold_sum[c%0d]: got %h, required 0002", cyc, if16.sum);
        else n_pass++;
      end
      if (if16.in_valid && if16.in_ready) begin
        q16.push_back(m16(16'(sent + 1), 16'(sent + 1), 1'b0, 1'b0));
        sent++;
      end
      @(posedge clk); #1;
    end
    if16.out_ready = 1'b1;
    n_chk++;
    if (sent !== 4 || q16.size() !== 0)
      $display("FAIL bp_complete: got sent=%0d pending=%0d, required sent=4 pending=0", sent, q16.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int          sent = 0;
    logic        stalled = 1'b0;
    logic [17:0] prev = '0;
    for (int cyc = 0; cyc < 3000 && (sent < 40 || q16.size() != 0); cyc++) begin
      if (stalled) begin
        n_chk++;
        if (if16.out_valid !== 1'b1 || {if16.sum, if16.cout, if16.ovf} !== prev)
          $display("FAIL stall_hold[c%0d]: got valid=%b res=%h, required valid=1 res=%h",
                   cyc, if16.out_valid, {if16.sum, if16.cout, if16.ovf}, prev);
        else n_pass++;
      end
      if16.out_ready = ($urandom_range(0, 9) < 7);
      if (sent < 40) begin
        if16.in_valid = ($urandom_range(0, 9) < 7);
        if16.a   = 16'($urandom);
        if16.b   = 16'($urandom);
        if16.cin = 1'($urandom);
        if16.sub = 1'($urandom);
      end else begin
        if16.in_valid = 1'b0;
      end
      #1;
      if (if16.in_valid && if16.in_ready) begin
        q16.push_back(m16(if16.a, if16.b, if16.cin, if16.sub));
        sent++;
      end
      stalled = if16.out_valid && !if16.out_ready;
      prev    = {if16.sum, if16.cout, if16.ovf};
      @(posedge clk); #1;
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    n_chk++;
    if (sent !== 40 || q16.size() !== 0)
      $display("FAIL random_drain: got sent=%0d pending=%0d, required sent=40 pending=0", sent, q16.size());
    else n_pass++;
  endtask

  task automatic test_reset_flight();
    if16.out_ready = 1'b1;
    if16.cin = 1'b0; if16.sub = 1'b0;
    if16.in_valid = 1'b1; if16.a = 16'h0001; if16.b = 16'h0001;
    @(posedge clk); #1;
    if16.a = 16'h0002; if16.b = 16'h0002;
    @(posedge clk); #1;
    n_chk++;
    if (if16.out_valid !== 1'b1) $display("FAIL flight_before_reset: got valid=%b, required 1", if16.out_valid);
    else n_pass++;
    // A third operand is offered while reset is asserted and must be dropped.
    if16.a = 16'h0007; if16.b = 16'h0007;
    rst_n = 1'b0;
    q16.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    if16.in_valid = 1'b0;
    n_chk++;
    if ({if16.out_valid, if16.sum, if16.cout, if16.ovf} !== 19'd0)
      $display("FAIL flight_reset_state: got valid=%b sum=%h cout=%b ovf=%b, required all zero",
               if16.out_valid, if16.sum, if16.cout, if16.ovf);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (if16.out_valid !== 1'b0) $display("FAIL flight_no_output[%0d]: got valid=%b, required 0", i, if16.out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_params();
    logic [31:0] a32 [2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] b32 [2] = '{32'h0000_0001, 32'h0000_0001};
    logic        s32 [2] = '{1'b0, 1'b1};
    logic [33:0] e32 [2] = '{{32'h0000_0000, 1'b1, 1'b0}, {32'hFFFF_FFFF, 1'b0, 1'b0}};
    logic [15:0] a1  [2] = '{16'hFFFF, 16'h7FFF};
    logic [17:0] e1  [2] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1}};
    int          lat32;
    int          lat1;
    logic [33:0] g32;
    logic [17:0] g1;
    for (int v = 0; v < 2; v++) begin
      if32.a = a32[v]; if32.b = b32[v]; if32.sub = s32[v]; if32.cin = 1'b0; if32.in_valid = 1'b1;
      if1.a = a1[v]; if1.b = 16'h0001; if1.sub = 1'b0; if1.cin = 1'b0; if1.in_valid = 1'b1;
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      if1.in_valid  = 1'b0;
      lat32 = 0; lat1 = 0; g32 = '0; g1 = '0;
      for (int t = 1; t <= 10; t++) begin
        if (lat1 == 0 && if1.out_valid) begin
          lat1 = t; g1 = {if1.sum, if1.cout, if1.ovf};
        end
        if (lat32 == 0 && if32.out_valid) begin
          lat32 = t; g32 = {if32.sum, if32.cout, if32.ovf};
        end
        if (lat1 != 0 && lat32 != 0) break;
        @(posedge clk); #1;
      end
      n_chk++;
      if (lat1 !== 1) $display("FAIL s1_latency[%0d]: got %0d, required 1", v, lat1);
      else n_pass++;
      n_chk++;
      if (g1 !== e1[v]) $display("FAIL s1_result[%0d]: got %h, required %h", v, g1, e1[v]);
      else n_pass++;
      n_chk++;
      if (lat32 !== 4) $display("FAIL w32_latency[%0d]: got %0d, required 4", v, lat32);
      else n_pass++;
      n_chk++;
      if (g32 !== e32[v]) $display("FAIL w32_result[%0d]: got %h, required %h", v, g32, e32[v]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_reset_flight();
    test_params();
    n_chk++;
    if (q16.size() !== 0) $display("FAIL final_queue: got %0d pending, required 0", q16.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit combinational CLA.
- W-bit operands are split into STAGES equal slices. Each slice is resolved by 4-bit generate/propagate lookahead groups in one clock, with the carry registered between slices.
- Valid/ready handshake on both sides so it drops into the ALU datapath or multi-cycle arithmetic units at full throughput with backpressure.

Parameters:
- W, 16, operand/sum width; must be a multiple of 4*STAGES, range 4..64.
- STAGES, 2, pipeline depth in cycles; each stage resolves W/STAGES bits; range 1..W/4.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  a/b/cin/sub valid this cycle
- in_ready  out  1  stage 0 can accept; transfer when in_valid & in_ready
- a  in  W  first operand
- b  in  W  second operand
- cin  in  1  carry-in, used only when sub=0
- sub  in  1  1: a - b computed as a + ~b + 1, cin ignored
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready
- sum  out  W  a + b' + c0, mod 2^W
- cout  out  1  carry out of bit W-1; for sub, 1 = no borrow
- ovf  out  1  signed overflow: carry into bit W-1 XOR carry out of bit W-1

Behaviour:
- Operand prep at input: b' = sub ? ~b : b; c0 = sub ? 1 : cin.
- Per-bit g = a&b', p = a|b'; per-group lookahead as 4-bit g/p groups chained within a stage; sum bit = a ^ b' ^ carry.
- Stage k (0..STAGES-1) holds: valid bit; sum bits for slices 0..k; a/b' for slices k+1..; registered carry out of slice k.
- Stage k computes slice k from registered/input operands plus incoming carry (c0 for k=0, registered carry for k>0).
- Last stage also registers ovf = carry into MSB ^ carry out of MSB, and cout.
- Latency: exactly STAGES cycles from input handshake to out_valid with out_ready held 1.
- STAGES=1 degenerates to one registered W-bit CLA, latency 1.
- Throughput: one result per cycle when out_ready=1.
- Flow control: stage k loads when its valid=0 or stage k+1 loads (last stage: out_ready=1).
- in_ready = stage-0 load condition, combinational from out_ready chain. No bubble insertion; no skid buffer.
- Stall: while out_valid=1 and out_ready=0, sum/cout/ovf and all stage contents hold exactly. Stages with valid=0 still fill upstream, compacting bubbles.
- Data in a stage with valid=0 is don't-care. sum/cout/ovf register only on a load of the last stage.
- Results emerge strictly in input order; no drops or duplicates.
- Reset (rst_n=0 at clk edge): all valid bits 0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight results are discarded, nothing emerges afterwards; reset overrides any simultaneous handshake.
- in_ready may be 1 while rst_n=0, but no input transfer takes effect during reset.
- Wrap-around: carry out of MSB never affects sum; sum is modulo 2^W.

Test Plan:
- W=16, STAGES=2: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 2 cycles sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
- a=0x00FF, b=0x0001 (carry crosses the slice boundary at bit 8) -> sum=0x0100, cout=0.
- sub=1, a=0x0003, b=0x0005, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
- Backpressure: 4 back-to-back inputs (1+1, 2+2, 3+3, 4+4) with out_ready low cycles 3-5:
  - in_ready drops once both stages are full;
  - sum stays 0x0002 through the stall;
  - results 0x0002, 0x0004, 0x0006, 0x0008 appear in order, none lost.
- Reset: two transactions in flight, rst_n=0 for one cycle -> out_valid=0, sum=0 next cycle, neither result ever appears. Repeat STAGES=1 and W=32/STAGES=4 with a=0xFFFFFFFF, b=1 -> sum=0, cout=1, latency 1 and 4 respectively.
